fc_window_buf: RTL

- Generalised successor to the FC-stage SRAM data register.
- Selects one of GROUP_NUM SRAM groups, each SRAM_NUM banks wide, and aligns the selected data to the 1-cycle SRAM read latency.
- Packs BEATS consecutive reads into one window held in a two-entry ping-pong buffer.
- Presents each window to the FC MAC array over a valid/ready handshake with back-pressure toward the address generator.

---
 rtl/fc_window_buf.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fc_window_buf.sv
// FC-stage window buffer: selects an SRAM group, aligns it to the read
// latency, packs BEATS reads per window into a ping-pong pair.
//
// Ports:
//   clk, rst         clock, async active-high reset
//   sram_rdata       GROUP_NUM groups of BEAT_W bits, group g at [g*BEAT_W +: BEAT_W]
//   rd_en/rd_sel     read issued this cycle, and the group it targets
//   rd_last          this read closes the window early
//   rd_ready         a read issued now will be accepted
//   win_valid/ready  window handshake toward the MAC array
//   win_data         window, beat 0 in the MSB slice
//   win_beats        beats written into the presented window
//   ovf_err/sel_err  sticky: dropped read / out-of-range group
module fc_window_buf #(
  parameter int DATA_WIDTH            = 8,
  parameter int DATA_NUM_PER_SRAM_ADDR = 4,
  parameter int SRAM_NUM              = 5,
  parameter int GROUP_NUM             = 3,
  parameter int BEATS                 = 4,
  localparam int BEAT_W = DATA_NUM_PER_SRAM_ADDR * DATA_WIDTH * SRAM_NUM,
  localparam int WIN_W  = BEATS * BEAT_W,
  localparam int SEL_W  = (GROUP_NUM > 1) ? $clog2(GROUP_NUM) : 1,
  localparam int CNT_W  = $clog2(BEATS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [GROUP_NUM*BEAT_W-1:0] sram_rdata,
  input  logic                        rd_en,
  input  logic [SEL_W-1:0]            rd_sel,
  input  logic                        rd_last,
  output logic                        rd_ready,
  output logic                        win_valid,
  input  logic                        win_ready,
  output logic [WIN_W-1:0]            win_data,
  output logic [CNT_W-1:0]            win_beats,
  output logic                        ovf_err,
  output logic                        sel_err
);

  logic [WIN_W-1:0]  buf_q   [2];
  logic [WIN_W-1:0]  buf_d   [2];
  logic [CNT_W-1:0]  beats_q [2];
  logic [CNT_W-1:0]  beats_d [2];
  logic [1:0]        full_cnt_q, full_cnt_d;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic              v1_q, last1_q;
  logic [SEL_W-1:0]  sel1_q;
  logic              ovf_q, sel_err_q;

  logic [BEAT_W-1:0] slice;
  logic              sel_hit;
  logic              close_next;
  logic              close;
  logic              pop;
  logic              accept;

  assign close_next = last1_q | (beat_cnt_q == CNT_W'(BEATS - 1));
  assign close      = v1_q & close_next;
  assign win_valid  = (full_cnt_q != 2'd0);
  assign pop        = win_valid & win_ready;

  // Conservative: a same-cycle pop never raises rd_ready, so every
  // in-flight beat is guaranteed a free fill buffer.
  assign rd_ready = (full_cnt_q == 2'd0) |
                    ((full_cnt_q == 2'd1) & ~(v1_q & close_next));
  assign accept   = rd_en & rd_ready;

  assign win_data  = buf_q[rd_ptr_q];
  assign win_beats = beats_q[rd_ptr_q];
  assign ovf_err   = ovf_q;
  assign sel_err   = sel_err_q;

  // Group mux; an out-of-range select yields zeros.
  always_comb begin
    slice   = '0;
    sel_hit = 1'b0;
    for (int g = 0; g < GROUP_NUM; g++) begin
      if (sel1_q == SEL_W'(g)) begin
        slice   = sram_rdata[g*BEAT_W +: BEAT_W];
        sel_hit = 1'b1;
      end
    end
  end

  always_comb begin
    buf_d   = buf_q;
    beats_d = beats_q;
    // Clear on pop so an early-closed window reads zero in unwritten slots.
    if (pop) begin
      buf_d[rd_ptr_q]   = '0;
      beats_d[rd_ptr_q] = '0;
    end
    if (v1_q) begin
      for (int b = 0; b < BEATS; b++) begin
        if (beat_cnt_q == CNT_W'(b))
          buf_d[wr_ptr_q][(BEATS-1-b)*BEAT_W +: BEAT_W] = slice;
      end
      if (close)
        beats_d[wr_ptr_q] = beat_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    full_cnt_d = full_cnt_q;
    unique case ({close, pop})
      2'b10:   full_cnt_d = full_cnt_q + 2'd1;
      2'b01:   full_cnt_d = full_cnt_q - 2'd1;
      default: full_cnt_d = full_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      beats_q[0] <= '0;
      beats_q[1] <= '0;
      full_cnt_q <= '0;
      beat_cnt_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      v1_q       <= 1'b0;
      sel1_q     <= '0;
      last1_q    <= 1'b0;
      ovf_q      <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
      beats_q[0] <= beats_d[0];
      beats_q[1] <= beats_d[1];
      full_cnt_q <= full_cnt_d;
      v1_q       <= accept;
      if (accept) begin
        sel1_q  <= rd_sel;
        last1_q <= rd_last;
      end
      if (v1_q)
        beat_cnt_q <= close ? '0 : beat_cnt_q + CNT_W'(1);
      if (close)
        wr_ptr_q <= ~wr_ptr_q;
      if (pop)
        rd_ptr_q <= ~rd_ptr_q;
      if (rd_en & ~rd_ready)
        ovf_q <= 1'b1;
      if (v1_q & ~sel_hit)
        sel_err_q <= 1'b1;
    end
  end

endmodule
